// File: rtl/neuron_column_sched.sv
// Time-multiplexed integrate-and-fire column: one shared weighted-sum and
// threshold datapath evaluates NUM_NEURONS neurons, one per cycle.
// Ports: clk, rst (sync, active-high), start, spikes_in -> volley capture;
// w_ren, w_addr, w_rdata -> 1-cycle-latency weight RAM;
// busy, done, spikes_out, fired, winner -> status and column result.
module neuron_column_sched #(
  parameter int NUM_NEURONS = 16,
  parameter int NUM_SPIKES  = 64,
  parameter int WBITS       = 3,
  parameter int THRESHOLD   = 16,
  parameter int AW          = $clog2(NUM_NEURONS),
  parameter int SUM_W       = $clog2(NUM_SPIKES*(2**WBITS-1)+1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NUM_SPIKES-1:0]       spikes_in,
  output logic                        w_ren,
  output logic [AW-1:0]               w_addr,
  input  logic [NUM_SPIKES*WBITS-1:0] w_rdata,
  output logic                        busy,
  output logic                        done,
  output logic [NUM_NEURONS-1:0]      spikes_out,
  output logic                        fired,
  output logic [AW-1:0]               winner
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           idx_q, idx_d;
  logic [AW-1:0]           tag_q, tag_d;
  logic                    v_q, v_d;
  logic [NUM_SPIKES-1:0]   spk_q, spk_d;
  logic [NUM_NEURONS-1:0]  vec_q, vec_d;
  logic [NUM_NEURONS-1:0]  so_q, so_d;
  logic                    fired_q, fired_d;
  logic [AW-1:0]           win_q, win_d;
  logic [SUM_W-1:0]        sum;
  logic                    hit;

  // Lowest set index wins; 0 when the vector is empty.
  function automatic logic [AW-1:0] prio(
    input logic [NUM_NEURONS-1:0] v
  );
    prio = '0;
    for (int n = NUM_NEURONS-1; n >= 0; n--) begin
      if (v[n]) prio = AW'(n);
    end
  endfunction

  // Weighted sum of the captured volley against the fetched weights.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_SPIKES; i++) begin
      if (spk_q[i]) begin
        sum = sum + SUM_W'(w_rdata[i*WBITS +: WBITS]);
      end
    end
    hit = (int'(sum) > THRESHOLD);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tag_d   = tag_q;
    v_d     = 1'b0;
    spk_d   = spk_q;
    vec_d   = vec_q;
    so_d    = so_q;
    fired_d = fired_q;
    win_d   = win_q;
    // w_rdata answers the fetch issued last cycle, tagged in tag_q.
    if (v_q) vec_d[tag_q] = hit;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          spk_d   = spikes_in;
          vec_d   = '0;
          idx_d   = '0;
        end
      end
      S_RUN: begin
        v_d   = 1'b1;
        tag_d = idx_q;
        if (idx_q == AW'(NUM_NEURONS-1)) begin
          state_d = S_DRAIN;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      S_DRAIN: begin
        // Publish including the last neuron evaluated this cycle.
        state_d = S_DONE;
        so_d    = vec_d;
        fired_d = |vec_d;
        win_d   = prio(vec_d);
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tag_q   <= '0;
      v_q     <= 1'b0;
      spk_q   <= '0;
      vec_q   <= '0;
      so_q    <= '0;
      fired_q <= 1'b0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tag_q   <= tag_d;
      v_q     <= v_d;
      spk_q   <= spk_d;
      vec_q   <= vec_d;
      so_q    <= so_d;
      fired_q <= fired_d;
      win_q   <= win_d;
    end
  end

  assign w_ren      = (state_q == S_RUN);
  assign w_addr     = idx_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign spikes_out = so_q;
  assign fired      = fired_q;
  assign winner     = win_q;

endmodule

// File: tb/tb_neuron_column_sched.sv
// Self-checking bench for neuron_column_sched with a 1-cycle weight RAM
// model and a scoreboard of expected column results.
module tb_neuron_column_sched;
  localparam int N  = 16;
  localparam int S  = 64;
  localparam int WB = 3;
  localparam int AW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [S-1:0]    spikes_in;
  logic            w_ren;
  logic [AW-1:0]   w_addr;
  logic [S*WB-1:0] w_rdata;
  logic            busy;
  logic            done;
  logic [N-1:0]    spikes_out;
  logic            fired;
  logic [AW-1:0]   winner;

  always #5 clk = ~clk;

  neuron_column_sched dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .spikes_in (spikes_in),
    .w_ren     (w_ren),
    .w_addr    (w_addr),
    .w_rdata   (w_rdata),
    .busy      (busy),
    .done      (done),
    .spikes_out(spikes_out),
    .fired     (fired),
    .winner    (winner)
  );

  logic [S*WB-1:0] mem [N];

  always @(posedge clk) begin
    if (w_ren) w_rdata <= mem[w_addr];
  end

  typedef struct packed {
    logic [N-1:0]  so;
    logic          f;
    logic [AW-1:0] w;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  function automatic exp_t model(input logic [S-1:0] spk);
    exp_t e;
    int   sum;
    e = '0;
    for (int n = 0; n < N; n++) begin
      sum = 0;
      for (int i = 0; i < S; i++) begin
        if (spk[i]) sum += int'(mem[n][i*WB +: WB]);
      end
      if (sum > 16) e.so[n] = 1'b1;
    end
    e.f = |e.so;
    for (int n = N-1; n >= 0; n--) begin
      if (e.so[n]) e.w = AW'(n);
    end
    return e;
  endfunction

  task automatic fill_random();
    for (int n = 0; n < N; n++) begin
      mem[n] = {$urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom};
    end
  endtask

  task automatic pulse_start(input logic [S-1:0] spk);
    @(negedge clk);
    start     = 1'b1;
    spikes_in = spk;
    sb.push_back(model(spk));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    start     = 1'b0;
    spikes_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({w_ren, busy, done} !== 3'b000)
      $display("FAIL reset_ctl got %b want 000", {w_ren, busy, done});
    else passed++;
    total++;
    if ({spikes_out, fired, winner, w_addr} !== '0)
      $display("FAIL reset_out so=%h f=%b w=%0d a=%0d want 0",
               spikes_out, fired, winner, w_addr);
    else passed++;
  endtask

  task automatic test_timing();
    exp_t e;
    fill_random();
    pulse_start({$urandom, $urandom});
    for (int k = 0; k < N; k++) begin
      total++;
      if (!(w_ren === 1'b1 && w_addr === AW'(k) && busy === 1'b1))
        $display("FAIL fetch_%0d ren=%b addr=%0d busy=%b want 1/%0d/1",
                 k, w_ren, w_addr, busy, k);
      else passed++;
      @(negedge clk);
    end
    total++;
    if ({w_ren, done, busy} !== 3'b001)
      $display("FAIL drain got %b want 001", {w_ren, done, busy});
    else passed++;
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if (done !== 1'b1 || busy !== 1'b1)
      $display("FAIL done_c18 done=%b busy=%b want 1/1", done, busy);
    else passed++;
    total++;
    if ({spikes_out, fired, winner} !== {e.so, e.f, e.w})
      $display("FAIL timing_res so=%h f=%b w=%0d want %h/%b/%0d",
               spikes_out, fired, winner, e.so, e.f, e.w);
    else passed++;
    @(negedge clk);
    total++;
    if ({done, busy} !== 2'b00)
      $display("FAIL post_done got %b want 00", {done, busy});
    else passed++;
  endtask

  task automatic load_boundary_mem();
    for (int n = 0; n < N; n++) mem[n] = '0;
    for (int i = 0; i < 16; i++) mem[3][i*WB +: WB] = 3'd1;
    for (int i = 0; i < 17; i++) mem[5][i*WB +: WB] = 3'd1;
    for (int i = 0; i < 15; i++) mem[9][i*WB +: WB] = 3'd1;
    mem[9][15*WB +: WB] = 3'd2;
  endtask

  task automatic test_threshold();
    exp_t e;
    int   lat;
    load_boundary_mem();
    pulse_start({48'h0, 16'hFFFF});
    wait_done(lat);
    e = sb.pop_front();
    total++;
    if (lat !== 18)
      $display("FAIL thr_latency got %0d want 18", lat);
    else passed++;
    total++;
    if ({spikes_out, fired, winner} !== {16'h0200, 1'b1, 4'd9})
      $display("FAIL thr_res so=%h f=%b w=%0d want 0200/1/9",
               spikes_out, fired, winner);
    else passed++;
    total++;
    if ({spikes_out, fired, winner} !== {e.so, e.f, e.w})
      $display("FAIL thr_sb so=%h f=%b w=%0d want %h/%b/%0d",
               spikes_out, fired, winner, e.so, e.f, e.w);
    else passed++;
  endtask

  task automatic test_full_scale();
    exp_t e;
    int   lat;
    for (int n = 0; n < N; n++) mem[n] = '1;
    pulse_start('1);
    wait_done(lat);
    e = sb.pop_front();
    total++;
    if (lat !== 18)
      $display("FAIL full_latency got %0d want 18", lat);
    else passed++;
    total++;
    if ({spikes_out, fired, winner} !== {16'hFFFF, 1'b1, 4'd0})
      $display("FAIL full_res so=%h f=%b w=%0d want FFFF/1/0",
               spikes_out, fired, winner);
    else passed++;
    total++;
    if (spikes_out !== e.so)
      $display("FAIL full_sb so=%h want %h", spikes_out, e.so);
    else passed++;
  endtask

  task automatic test_no_fire();
    exp_t e;
    int   lat;
    fill_random();
    pulse_start('0);
    wait_done(lat);
    e = sb.pop_front();
    total++;
    if (lat !== 18 || done !== 1'b1)
      $display("FAIL nofire_done lat=%0d done=%b want 18/1", lat, done);
    else passed++;
    total++;
    if ({spikes_out, fired, winner} !== {e.so, e.f, e.w} ||
        e.so !== '0)
      $display("FAIL nofire_res so=%h f=%b w=%0d want 0/0/0",
               spikes_out, fired, winner);
    else passed++;
  endtask

  task automatic test_busy_hold();
    exp_t         e;
    exp_t         first;
    logic [S-1:0] spk1;
    logic [S-1:0] spk2;
    bit           want;
    int           ndone;
    spk1  = {48'h0, 16'hFFFF};
    spk2  = '1;
    ndone = 0;
    first = '0;
    load_boundary_mem();
    @(negedge clk);
    start     = 1'b1;
    spikes_in = spk1;
    sb.push_back(model(spk1));
    for (int t = 1; t <= 60; t++) begin
      @(negedge clk);
      if (t == 5)  spikes_in = spk2;
      if (t == 40) start = 1'b0;
      if (t == 19 || t == 38) sb.push_back(model(spikes_in));
      want = (t == 18 || t == 37 || t == 56);
      total++;
      if (done !== want)
        $display("FAIL busy_done_t%0d got %b want %b", t, done, want);
      else passed++;
      if (want) begin
        ndone++;
        e = sb.pop_front();
        if (t == 18) first = e;
        total++;
        if ({spikes_out, fired, winner} !== {e.so, e.f, e.w})
          $display("FAIL busy_res_t%0d so=%h f=%b w=%0d want %h/%b/%0d",
                   t, spikes_out, fired, winner, e.so, e.f, e.w);
        else passed++;
      end
      if (t > 18 && t < 37) begin
        total++;
        if ({spikes_out, fired, winner} !== {first.so, first.f, first.w})
          $display("FAIL hold_t%0d so=%h want %h", t, spikes_out, first.so);
        else passed++;
      end
    end
    total++;
    if (ndone !== 3 || first.so !== 16'h0200)
      $display("FAIL busy_count got %0d/%h want 3/0200", ndone, first.so);
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    int   lat;
    int   nd;
    fill_random();
    @(negedge clk);
    start     = 1'b1;
    spikes_in = {$urandom, $urandom};
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({busy, done, w_ren, fired} !== 4'b0000 || spikes_out !== '0 ||
        winner !== '0)
      $display("FAIL midrst got b=%b d=%b r=%b so=%h want all 0",
               busy, done, w_ren, spikes_out);
    else passed++;
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) nd++;
    end
    total++;
    if (nd !== 0)
      $display("FAIL midrst_nodone got %0d want 0", nd);
    else passed++;
    pulse_start({$urandom, $urandom});
    wait_done(lat);
    e = sb.pop_front();
    total++;
    if (lat !== 18)
      $display("FAIL rerun_latency got %0d want 18", lat);
    else passed++;
    total++;
    if ({spikes_out, fired, winner} !== {e.so, e.f, e.w})
      $display("FAIL rerun_res so=%h f=%b w=%0d want %h/%b/%0d",
               spikes_out, fired, winner, e.so, e.f, e.w);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_timing();
    test_threshold();
    test_full_scale();
    test_no_fire();
    test_busy_hold();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
